// File: rtl/aes_round_ctrl.sv
// Control sequencer for an iterative AES-128 encryption datapath: accepts a block,
// walks round keys 0..NR over req/ack, then holds the ciphertext until it is taken.
module aes_round_ctrl #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          load_pt,
    output logic          key_req,
    output logic [RW-1:0] key_round,
    input  logic          key_ack,
    output logic          state_en,
    output logic [1:0]    op_sel,
    output logic          busy,
    output logic          out_valid,
    input  logic          out_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT  = 2'b00,
        OP_FULL  = 2'b01,
        OP_FINAL = 2'b10
    } op_t;

    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    state_t        r_state;
    logic [RW-1:0] r_round_cnt;
    logic          r_in_ready;
    logic          r_key_req;
    logic          r_out_valid;
    logic          r_busy;

    logic          w_accept;
    logic          w_key_xfer;
    logic          w_last;

    // abort masks every handshake in its own cycle, so the datapath never moves on it
    assign in_ready   = r_in_ready & ~abort;
    assign w_accept   = in_ready & in_valid;
    assign w_key_xfer = r_key_req & key_ack & ~abort;
    assign w_last     = (r_round_cnt == LAST_ROUND);

    assign load_pt    = w_accept;
    assign state_en   = w_key_xfer;
    assign key_req    = r_key_req;
    assign key_round  = r_key_req ? r_round_cnt : '0;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid & ~abort;

    always_comb begin
        // NOTE: default assigned first so every path drives op_sel and no latch is inferred
        op_sel = OP_INIT;
        if (w_key_xfer && (r_round_cnt != '0)) begin
            op_sel = w_last ? OP_FINAL : OP_FULL;
        end
    end

    // NOTE: state uses non-blocking assignments so every register updates from pre-edge values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_round_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_key_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (abort) begin
            r_state     <= S_IDLE;
            r_round_cnt <= '0;
            r_in_ready  <= 1'b1;
            r_key_req   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_KEY;
                        r_round_cnt <= '0;
                        r_in_ready  <= 1'b0;
                        r_key_req   <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_KEY: begin
                    if (w_key_xfer) begin
                        if (w_last) begin
                            r_state     <= S_DONE;
                            r_key_req   <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_round_cnt <= r_round_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_round_cnt <= '0;
                    r_in_ready  <= 1'b1;
                    r_key_req   <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
